// File: rtl/bcd_updown_counter_pkg.sv
// Shared constants for the BCD up/down counter: nibble width, digit limit and
// active-low 7-segment patterns ordered {g,f,e,d,c,b,a}.
package bcd_updown_counter_pkg;

    localparam int NIBBLE_W   = 4;
    localparam int MAX_DIGITS = 4;

    typedef logic [6:0]          seg_t;
    typedef logic [NIBBLE_W-1:0] bcd_t;

    localparam seg_t SEG_0     = 7'b1000000;
    localparam seg_t SEG_1     = 7'b1111001;
    localparam seg_t SEG_2     = 7'b0100100;
    localparam seg_t SEG_3     = 7'b0110000;
    localparam seg_t SEG_4     = 7'b0011001;
    localparam seg_t SEG_5     = 7'b0010010;
    localparam seg_t SEG_6     = 7'b0000010;
    localparam seg_t SEG_7     = 7'b1111000;
    localparam seg_t SEG_8     = 7'b0000000;
    localparam seg_t SEG_9     = 7'b0010000;
    localparam seg_t SEG_BLANK = 7'b1111111;

    function automatic seg_t seg_decode(input bcd_t n);
        case (n)
            4'd0:    return SEG_0;
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            default: return SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/bcd_updown_counter_btn_pulse.sv
// Button conditioner: two-flop synchroniser, stability debouncer and a
// single-cycle pulse on each rising edge of the debounced level.
module btn_pulse #(
    parameter int DEB_CYCLES = 1000000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic pulse
);

    localparam int CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    logic             sync_q1;
    logic             sync_q2;
    logic             level;
    logic [CNT_W-1:0] deb_cnt;

    // NOTE: every register here uses <= so all flops sample pre-edge values;
    // with = the second synchroniser stage would collapse into the first.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
            level   <= 1'b0;
            deb_cnt <= '0;
            pulse   <= 1'b0;
        end else begin
            sync_q1 <= btn;
            sync_q2 <= sync_q1;
            pulse   <= 1'b0;
            // Count consecutive samples that disagree with the debounced level.
            if (sync_q2 != level) begin
                if (deb_cnt == CNT_LAST) begin
                    level   <= sync_q2;
                    deb_cnt <= '0;
                    pulse   <= sync_q2;
                end else begin
                    deb_cnt <= deb_cnt + CNT_W'(1);
                end
            end else begin
                deb_cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/bcd_updown_counter.sv
// Debounced-button BCD up/down counter with sticky wrap flag and a
// time-multiplexed, active-low 7-segment display driver.
module bcd_updown_counter
    import bcd_updown_counter_pkg::*;
#(
    parameter int DIGITS      = 4,
    parameter int DEB_CYCLES  = 1000000,
    parameter int SCAN_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_clr,
    output logic [6:0] leds,
    output logic [3:0] ano,
    output logic       ovf
);

    localparam int SCAN_W = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_CYCLES - 1);
    localparam logic [1:0]        IDX_LAST  = 2'(DIGITS - 1);

    logic up_p, down_p, clr_p;

    btn_pulse #(.DEB_CYCLES(DEB_CYCLES)) u_up   (.clk(clk), .reset(reset), .btn(btn_up),   .pulse(up_p));
    btn_pulse #(.DEB_CYCLES(DEB_CYCLES)) u_down (.clk(clk), .reset(reset), .btn(btn_down), .pulse(down_p));
    btn_pulse #(.DEB_CYCLES(DEB_CYCLES)) u_clr  (.clk(clk), .reset(reset), .btn(btn_clr),  .pulse(clr_p));

    bcd_t [DIGITS-1:0] count;
    bcd_t [DIGITS-1:0] count_inc;
    bcd_t [DIGITS-1:0] count_dec;
    logic              inc_wrap;
    logic              dec_wrap;

    // NOTE: each output of this block gets a default before any branch so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        count_inc = count;
        count_dec = count;
        inc_wrap  = 1'b1;
        dec_wrap  = 1'b1;
        // Carry/borrow ripples upward only while lower digits wrap; a flag
        // still set after the last digit means the whole count wrapped.
        for (int i = 0; i < DIGITS; i++) begin
            if (inc_wrap) begin
                if (count[i] == 4'd9) begin
                    count_inc[i] = 4'd0;
                end else begin
                    count_inc[i] = count[i] + 4'd1;
                    inc_wrap     = 1'b0;
                end
            end
            if (dec_wrap) begin
                if (count[i] == 4'd0) begin
                    count_dec[i] = 4'd9;
                end else begin
                    count_dec[i] = count[i] - 4'd1;
                    dec_wrap     = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
            ovf   <= 1'b0;
        end else if (clr_p) begin
            count <= '0;
            ovf   <= 1'b0;
        end else if (up_p && !down_p) begin
            count <= count_inc;
            if (inc_wrap) ovf <= 1'b1;
        end else if (down_p && !up_p) begin
            count <= count_dec;
            if (dec_wrap) ovf <= 1'b1;
        end
    end

    logic [SCAN_W-1:0] scan_cnt;
    logic [1:0]        scan_idx;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scan_cnt <= '0;
            scan_idx <= '0;
        end else if (scan_cnt == SCAN_LAST) begin
            scan_cnt <= '0;
            scan_idx <= (scan_idx == IDX_LAST) ? 2'd0 : scan_idx + 2'd1;
        end else begin
            scan_cnt <= scan_cnt + SCAN_W'(1);
        end
    end

    logic [3:0] ano_next;
    bcd_t       digit_sel;

    always_comb begin
        ano_next  = 4'b1111;
        digit_sel = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (scan_idx == 2'(i)) begin
                ano_next[i] = 1'b0;
                digit_sel   = count[i];
            end
        end
    end

    // Enable and segments share one register stage so they always line up.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ano  <= 4'b1111;
            leds <= SEG_BLANK;
        end else begin
            ano  <= ano_next;
            leds <= seg_decode(digit_sel);
        end
    end

endmodule

// File: tb/tb_bcd_updown_counter.sv
// Scoreboarded bench: stimulus queues expected counts, a monitor reads the
// count back off the multiplexed display and compares.
module tb_bcd_updown_counter;

    logic       clk = 1'b0;
    logic       reset;
    logic       btn_up, btn_down, btn_clr;
    logic [6:0] leds;
    logic [3:0] ano;
    logic       ovf;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int   tens;
        int   ones;
        logic ovf;
    } exp_t;

    exp_t sb_q[$];
    logic mon_busy = 1'b0;

    bcd_updown_counter #(.DIGITS(2), .DEB_CYCLES(4), .SCAN_CYCLES(2)) dut (
        .clk(clk), .reset(reset), .btn_up(btn_up), .btn_down(btn_down),
        .btn_clr(btn_clr), .leds(leds), .ano(ano), .ovf(ovf)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] tb_seg(input int d);
        case (d)
            0:       return 7'b1000000;
            1:       return 7'b1111001;
            2:       return 7'b0100100;
            3:       return 7'b0110000;
            4:       return 7'b0011001;
            5:       return 7'b0010010;
            6:       return 7'b0000010;
            7:       return 7'b1111000;
            8:       return 7'b0000000;
            9:       return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: for each queued expectation, catch each digit as it is scanned.
    initial begin
        exp_t e;
        logic got;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                mon_busy = 1'b1;
                e = sb_q.pop_front();
                for (int d = 0; d < 2; d++) begin
                    got = 1'b0;
                    for (int t = 0; t < 16 && !got; t++) begin
                        @(negedge clk);
                        if (ano == ~(4'b0001 << d)) got = 1'b1;
                    end
                    check($sformatf("digit%0d_seen", d), 32'(got), 32'd1);
                    check($sformatf("digit%0d_leds", d), 32'(leds), 32'(tb_seg(d == 0 ? e.ones : e.tens)));
                end
                check("ovf", 32'(ovf), 32'(e.ovf));
                mon_busy = 1'b0;
            end
        end
    end

    task automatic expect_count(input int value, input logic o);
        exp_t e;
        logic done;
        e.tens = value / 10;
        e.ones = value % 10;
        e.ovf  = o;
        sb_q.push_back(e);
        done = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(posedge clk);
            if (sb_q.size() == 0 && !mon_busy) done = 1'b1;
        end
        if (!done) check("scoreboard_drain", 32'(done), 32'd1);
    endtask

    task automatic press(input logic u, input logic d, input logic c);
        @(posedge clk); #1;
        btn_up = u; btn_down = d; btn_clr = c;
        repeat (8) @(posedge clk);
        #1;
        btn_up = 1'b0; btn_down = 1'b0; btn_clr = 1'b0;
        repeat (8) @(posedge clk);
    endtask

    logic [3:0] a_hist[8];
    logic [6:0] l_hist[8];

    initial begin
        reset = 1'b1; btn_up = 1'b0; btn_down = 1'b0; btn_clr = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_ano", 32'(ano), 32'hF);
        check("reset_leds", 32'(leds), 32'h7F);
        check("reset_ovf", 32'(ovf), 32'd0);
        @(posedge clk); #1 reset = 1'b0;

        // Short glitch shorter than the debounce window.
        @(posedge clk); #1 btn_up = 1'b1;
        repeat (3) @(posedge clk);
        #1 btn_up = 1'b0;
        repeat (12) @(posedge clk);
        expect_count(0, 1'b0);

        repeat (9) press(1, 0, 0);
        expect_count(9, 1'b0);
        press(1, 0, 0);
        expect_count(10, 1'b0);

        press(0, 0, 1);
        repeat (99) press(1, 0, 0);
        expect_count(99, 1'b0);
        press(1, 0, 0);
        expect_count(0, 1'b1);
        press(1, 0, 0);
        expect_count(1, 1'b1);
        press(0, 0, 1);
        expect_count(0, 1'b0);

        press(0, 1, 0);
        expect_count(99, 1'b1);
        press(0, 0, 1);
        expect_count(0, 1'b0);

        press(1, 0, 0);
        press(1, 1, 0);
        expect_count(1, 1'b0);
        press(1, 0, 1);
        expect_count(0, 1'b0);

        repeat (42) press(1, 0, 0);
        expect_count(42, 1'b0);

        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            a_hist[i] = ano;
            l_hist[i] = leds;
        end
        for (int i = 0; i < 8; i++) begin
            check("scan_ano_legal", 32'(a_hist[i] == 4'b1110 || a_hist[i] == 4'b1101), 32'd1);
            check("scan_ano_hi", 32'(a_hist[i][3:2]), 32'h3);
            check("scan_leds", 32'(l_hist[i]), 32'(tb_seg(a_hist[i] == 4'b1110 ? 2 : 4)));
        end
        for (int i = 0; i < 6; i++)
            check("scan_alternate", 32'(a_hist[i+2] != a_hist[i]), 32'd1);

        // Asynchronous reset mid-scan, with btn_up held through release.
        @(posedge clk); #3 reset = 1'b1;
        #1;
        check("midscan_ano", 32'(ano), 32'hF);
        check("midscan_leds", 32'(leds), 32'h7F);
        check("midscan_ovf", 32'(ovf), 32'd0);
        btn_up = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        repeat (12) @(posedge clk);
        #1 btn_up = 1'b0;
        repeat (8) @(posedge clk);
        expect_count(1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
